// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers {pc, instr} for decode.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          resp_live;
  logic          resp_push;
  logic          pop;
  logic [CW-1:0] inflight_after_resp;
  logic [31:0]   redirect_target;

  // Credits cover both buffered entries and requests still in flight, so a response always has room.
  assign credit_used     = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid  = !rst && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;

  // Responses arriving with nothing outstanding are leftovers from before a reset.
  assign resp_live           = imem_resp_valid && (inflight != '0);
  assign resp_push           = resp_live && (drop == '0) && !redirect_valid;
  assign inflight_after_resp = resp_live ? (inflight - ONE_C) : inflight;
  assign redirect_target     = redirect_pc & 32'hFFFF_FFFC;

  assign id_valid = !rst && !redirect_valid && (count != '0);
  assign id_instr = rst ? 32'h0 : instr_mem[rd_ptr];
  assign id_pc    = rst ? 32'h0 : pc_mem[rd_ptr];
  assign pop      = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= 32'h0;
        instr_mem[i] <= 32'h0;
      end
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      pc       <= redirect_target;
      resp_pc  <= redirect_target;
      inflight <= inflight_after_resp;
      drop     <= inflight_after_resp;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire) begin
        pc <= pc + 32'd4;
      end
      inflight <= req_fire ? (inflight_after_resp + ONE_C) : inflight_after_resp;
      if (resp_live && (drop != '0)) begin
        drop <= drop - ONE_C;
      end
      if (resp_push) begin
        pc_mem[wr_ptr]    <= resp_pc;
        instr_mem[wr_ptr] <= imem_resp_data;
        wr_ptr            <= wr_ptr + ONE_P;
        resp_pc           <= resp_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
      case ({resp_push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_bubble  <= 32'h0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (id_ready && !id_valid) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for streaming/backpressure plus hand-written
// redirect and reset sequences, with a 1-cycle in-order memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubble(perf_bubble)
`endif
  );

  typedef struct {
    bit          rst, rdy, ren, idr;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          chk_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
    bit          chk_pc;
  } vec_t;

  vec_t        vecs [22];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] memq [$];
  logic [31:0] hs_pc [$];
  logic [31:0] hs_instr [$];
  logic [31:0] salt = 32'h0;
  bit          last_fire;
  int          fires;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Memory returns data one cycle after acceptance; data is tagged by address and salt.
  task automatic applyStimulus(input bit r, input bit rdy, input bit ren, input bit idr,
                               input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    rst            = r;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (ren && memq.size() > 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memq.pop_front();
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
    last_fire = imem_req_valid && imem_req_ready;
    if (last_fire) begin
      memq.push_back(~imem_req_addr ^ salt);
      fires++;
    end
    if (id_valid && id_ready) begin
      hs_pc.push_back(id_pc);
      hs_instr.push_back(id_instr);
    end
  endtask

  task automatic doReset();
    memq.delete();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    hs_pc.delete();
    hs_instr.delete();
  endtask

  task automatic runUntil(input int n);
    for (int k = 0; k < 40 && hs_pc.size() < n; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic checkStream(input string name, input logic [31:0] base, input int n);
    checkOutput({name, " count"}, 32'(hs_pc.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < hs_pc.size()) begin
        checkOutput($sformatf("%s pc%0d", name, k), hs_pc[k], base + 32'(4 * k));
        checkOutput($sformatf("%s instr%0d", name, k), hs_instr[k], ~(base + 32'(4 * k)));
      end
    end
    hs_pc.delete();
    hs_instr.delete();
  endtask

  task automatic checkFlags(input string name, input bit rv, input bit iv);
    checkOutput({name, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, rv});
    checkOutput({name, " id_valid"}, {31'b0, id_valid}, {31'b0, iv});
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;

    //          rst rdy ren idr  rv  addr       ca  iv  pc        cp
    vecs[0]  = '{1, 1, 1, 1,    0, 32'h00, 0,  0, 32'h00, 0};
    vecs[1]  = '{1, 1, 1, 1,    0, 32'h00, 1,  0, 32'h00, 1};
    vecs[2]  = '{0, 1, 1, 1,    1, 32'h00, 1,  0, 32'h00, 0};
    vecs[3]  = '{0, 1, 1, 1,    1, 32'h04, 1,  0, 32'h00, 0};
    vecs[4]  = '{0, 1, 1, 1,    0, 32'h08, 1,  1, 32'h00, 1};
    vecs[5]  = '{0, 1, 1, 1,    1, 32'h08, 1,  1, 32'h04, 1};
    vecs[6]  = '{0, 1, 1, 1,    1, 32'h0C, 1,  0, 32'h00, 0};
    vecs[7]  = '{0, 1, 1, 1,    0, 32'h10, 1,  1, 32'h08, 1};
    vecs[8]  = '{0, 1, 1, 0,    1, 32'h10, 1,  1, 32'h0C, 1};
    vecs[9]  = '{0, 1, 1, 0,    0, 32'h14, 1,  1, 32'h0C, 1};
    vecs[10] = '{0, 1, 1, 0,    0, 32'h14, 1,  1, 32'h0C, 1};
    vecs[11] = '{0, 1, 1, 0,    0, 32'h14, 1,  1, 32'h0C, 1};
    vecs[12] = '{0, 1, 1, 1,    0, 32'h14, 1,  1, 32'h0C, 1};
    vecs[13] = '{0, 1, 1, 1,    1, 32'h14, 1,  1, 32'h10, 1};
    vecs[14] = '{0, 1, 1, 1,    1, 32'h18, 1,  0, 32'h00, 0};
    vecs[15] = '{0, 1, 1, 1,    0, 32'h1C, 1,  1, 32'h14, 1};
    vecs[16] = '{0, 0, 1, 1,    1, 32'h1C, 1,  1, 32'h18, 1};
    vecs[17] = '{0, 0, 1, 1,    1, 32'h1C, 1,  0, 32'h00, 0};
    vecs[18] = '{0, 0, 1, 1,    1, 32'h1C, 1,  0, 32'h00, 0};
    vecs[19] = '{0, 1, 1, 1,    1, 32'h1C, 1,  0, 32'h00, 0};
    vecs[20] = '{0, 1, 1, 1,    1, 32'h20, 1,  0, 32'h00, 0};
    vecs[21] = '{0, 1, 1, 1,    0, 32'h24, 1,  1, 32'h1C, 1};

    memq.delete();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].ren, vecs[i].idr, 1'b0, 32'h0);
      checkFlags($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_iv);
      if (vecs[i].chk_addr)
        checkOutput($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].exp_addr);
      if (vecs[i].chk_pc) begin
        checkOutput($sformatf("vec%0d id_pc", i), id_pc, vecs[i].exp_pc);
        checkOutput($sformatf("vec%0d id_instr", i), id_instr,
                    vecs[i].exp_iv ? ~vecs[i].exp_pc : 32'h0);
      end
    end

    // Decode stalled from reset: only FIFO_DEPTH requests may be accepted.
    doReset();
    fires = 0;
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stall fires", 32'(fires), 32'd2);
    checkFlags("stall end", 1'b0, 1'b1);
    checkOutput("stall handshakes", 32'(hs_pc.size()), 32'd0);
    runUntil(6);
    checkStream("stall release", 32'h0, 6);

    // Two requests in flight then redirect: both old responses must be dropped.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10);
    checkFlags("redir setup", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("redir req0", imem_req_addr, 32'h10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("redir req1", imem_req_addr, 32'h14);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkFlags("redir full", 1'b0, 1'b0);
    checkOutput("redir held addr", imem_req_addr, 32'h18);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h103);
    checkFlags("redir cycle", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkFlags("redir drain", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkFlags("redir newreq", 1'b1, 1'b0);
    checkOutput("redir newaddr", imem_req_addr, 32'h100);
    runUntil(2);
    checkStream("redir stream", 32'h100, 2);

    // Redirect coinciding with a response and a ready decode, followed by a second redirect.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
    checkFlags("coinc cycle", 1'b0, 1'b0);
    checkOutput("coinc no hs", 32'(hs_pc.size()), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h201);
    checkFlags("coinc second", 1'b0, 1'b0);
    runUntil(3);
    checkStream("coinc stream", 32'h200, 3);

    // Reset with two responses pending; the stale data carries a salt so it is recognisable.
    doReset();
    salt = 32'h5A5A_0000;
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkFlags("rstpend full", 1'b0, 1'b0);
    salt = 32'h0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkFlags("rstpend reset", 1'b0, 1'b0);
    checkOutput("rstpend id_pc", id_pc, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkFlags("rstpend first", 1'b1, 1'b0);
    checkOutput("rstpend addr", imem_req_addr, 32'h0);
    runUntil(3);
    checkStream("rstpend stream", 32'h0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
